// File: rtl/kuuga_mem_pkg.sv
// Shared memory-side types: line-fill FSM states, requester identity, AXI constants.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package kuuga_mem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2
  } fill_state_t;

  typedef enum logic {
    OWNER_I = 1'b0,
    OWNER_D = 1'b1
  } owner_t;

  localparam logic [1:0] BURST_INCR = 2'b01;
  localparam logic [2:0] SIZE_4B    = 3'b010;
  localparam logic [1:0] RESP_OKAY  = 2'b00;

  // The requester that did not win last time gets the next tie.
  function automatic owner_t other_owner(input owner_t o);
    return (o == OWNER_I) ? OWNER_D : OWNER_I;
  endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-input round-robin arbiter: combinational winner, registered last owner.
// Latency: winner is combinational; last owner updates on the commit edge.
// Backpressure: none; commit is only asserted when the caller takes the grant.
module rr_arbiter2
  import kuuga_mem_pkg::*;
(
  input  logic   clk,
  input  logic   rst_n,
  input  logic   i_req,
  input  logic   d_req,
  input  logic   commit,
  output owner_t winner,
  output logic   any_req
);

  owner_t last_owner;

  // Single requester wins outright; a tie goes to whoever was not served last.
  always_comb begin
    any_req = i_req | d_req;
    winner  = OWNER_I;
    if (i_req && d_req) begin
      winner = other_owner(last_owner);
    end else if (d_req) begin
      winner = OWNER_D;
    end
  end

  // Remember who was served; reset favours the I side on the first tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_owner <= OWNER_D;
    end else if (commit) begin
      last_owner <= winner;
    end
  end

endmodule

// File: rtl/line_fill_arbiter.sv
// Shares one AXI4 read master between I-side and D-side cache line fills.
// Latency: arvalid one cycle after request sampled; read data forwarded combinationally.
// Backpressure: holds arvalid until arready; rready is held high for the whole data phase.
module line_fill_arbiter
  import kuuga_mem_pkg::*;
#(
  parameter int LINE_WORDS = 4,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_req_i,
  input  logic [ADDR_WIDTH-1:0] i_addr_i,
  output logic                  i_gnt_o,
  output logic                  i_rvalid_o,
  output logic [31:0]           i_rdata_o,
  output logic                  i_rlast_o,
  input  logic                  d_req_i,
  input  logic [ADDR_WIDTH-1:0] d_addr_i,
  output logic                  d_gnt_o,
  output logic                  d_rvalid_o,
  output logic [31:0]           d_rdata_o,
  output logic                  d_rlast_o,
  output logic [ADDR_WIDTH-1:0] m_araddr_o,
  output logic [7:0]            m_arlen_o,
  output logic [2:0]            m_arsize_o,
  output logic [1:0]            m_arburst_o,
  output logic                  m_arvalid_o,
  input  logic                  m_arready_i,
  input  logic [31:0]           m_rdata_i,
  input  logic [1:0]            m_rresp_i,
  input  logic                  m_rlast_i,
  input  logic                  m_rvalid_i,
  output logic                  m_rready_o,
  output logic                  err_o
);

  localparam int CNT_W = $clog2(LINE_WORDS);
  localparam logic [CNT_W-1:0]      LAST_BEAT = CNT_W'(LINE_WORDS - 1);
  localparam logic [ADDR_WIDTH-1:0] LINE_MASK = ADDR_WIDTH'(LINE_WORDS * 4 - 1);

  fill_state_t           state_q, state_d;
  owner_t                owner_q;
  owner_t                winner;
  logic                  any_req;
  logic                  start_fill;
  logic                  ar_hs;
  logic                  beat_acc;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [CNT_W-1:0]      beat_cnt_q;
  logic                  err_q;

  rr_arbiter2 u_rr (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_req  (i_req_i),
    .d_req  (d_req_i),
    .commit (start_fill),
    .winner (winner),
    .any_req(any_req)
  );

  assign m_araddr_o  = addr_q;
  assign m_arlen_o   = 8'(LINE_WORDS - 1);
  assign m_arsize_o  = SIZE_4B;
  assign m_arburst_o = BURST_INCR;
  assign err_o       = err_q;

  // Next state plus all state-decoded handshake and forwarding outputs.
  always_comb begin
    state_d     = state_q;
    m_arvalid_o = 1'b0;
    m_rready_o  = 1'b0;
    start_fill  = 1'b0;
    ar_hs       = 1'b0;
    beat_acc    = 1'b0;
    i_gnt_o     = 1'b0;
    d_gnt_o     = 1'b0;
    i_rvalid_o  = 1'b0;
    i_rdata_o   = 32'd0;
    i_rlast_o   = 1'b0;
    d_rvalid_o  = 1'b0;
    d_rdata_o   = 32'd0;
    d_rlast_o   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (any_req) begin
          start_fill = 1'b1;
          state_d    = ST_ADDR;
        end
      end
      ST_ADDR: begin
        m_arvalid_o = 1'b1;
        ar_hs       = m_arready_i;
        i_gnt_o     = ar_hs && (owner_q == OWNER_I);
        d_gnt_o     = ar_hs && (owner_q == OWNER_D);
        if (ar_hs) begin
          state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        m_rready_o = 1'b1;
        beat_acc   = m_rvalid_i;
        if (owner_q == OWNER_I) begin
          i_rvalid_o = m_rvalid_i;
          i_rdata_o  = m_rdata_i;
          i_rlast_o  = m_rlast_i;
        end else begin
          d_rvalid_o = m_rvalid_i;
          d_rdata_o  = m_rdata_i;
          d_rlast_o  = m_rlast_i;
        end
        // Only rlast ends the burst, even when the beat count disagrees.
        if (beat_acc && m_rlast_i) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Latch owner and line-aligned address when a fill is accepted from IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner_q <= OWNER_D;
      addr_q  <= '0;
    end else if (start_fill) begin
      owner_q <= winner;
      addr_q  <= ((winner == OWNER_I) ? i_addr_i : d_addr_i) & ~LINE_MASK;
    end
  end

  // Beat counter restarts at the AR handshake and steps per accepted beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat_cnt_q <= '0;
    end else if (ar_hs) begin
      beat_cnt_q <= '0;
    end else if (beat_acc) begin
      beat_cnt_q <= beat_cnt_q + CNT_W'(1);
    end
  end

  // Sticky error: bad response, or rlast not lining up with the final beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else if (beat_acc) begin
      if ((m_rresp_i != RESP_OKAY) || (m_rlast_i != (beat_cnt_q == LAST_BEAT))) begin
        err_q <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_line_fill_arbiter.sv
// Bench for line_fill_arbiter: directed fills against a transaction-level model.
// Latency: n/a.
// Backpressure: exercises arready stalls and rvalid gaps.
module tb_line_fill_arbiter;
  import kuuga_mem_pkg::*;

  localparam int LW = 4;
  localparam int AW = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          i_req = 1'b0, d_req = 1'b0;
  logic [AW-1:0] i_addr = '0, d_addr = '0;
  logic          i_gnt_o, i_rvalid_o, i_rlast_o, d_gnt_o, d_rvalid_o, d_rlast_o;
  logic [31:0]   i_rdata_o, d_rdata_o;
  logic [AW-1:0] m_araddr_o;
  logic [7:0]    m_arlen_o;
  logic [2:0]    m_arsize_o;
  logic [1:0]    m_arburst_o;
  logic          m_arvalid_o, m_rready_o, err_o;
  logic          m_arready = 1'b0, m_rlast = 1'b0, m_rvalid = 1'b0;
  logic [31:0]   m_rdata = '0;
  logic [1:0]    m_rresp = '0;

  always #5 clk = ~clk;

  line_fill_arbiter #(.LINE_WORDS(LW), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_req_i(i_req), .i_addr_i(i_addr), .i_gnt_o(i_gnt_o), .i_rvalid_o(i_rvalid_o),
    .i_rdata_o(i_rdata_o), .i_rlast_o(i_rlast_o),
    .d_req_i(d_req), .d_addr_i(d_addr), .d_gnt_o(d_gnt_o), .d_rvalid_o(d_rvalid_o),
    .d_rdata_o(d_rdata_o), .d_rlast_o(d_rlast_o),
    .m_araddr_o(m_araddr_o), .m_arlen_o(m_arlen_o), .m_arsize_o(m_arsize_o),
    .m_arburst_o(m_arburst_o), .m_arvalid_o(m_arvalid_o), .m_arready_i(m_arready),
    .m_rdata_i(m_rdata), .m_rresp_i(m_rresp), .m_rlast_i(m_rlast), .m_rvalid_i(m_rvalid),
    .m_rready_o(m_rready_o), .err_o(err_o)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction-level model: phase 0 waiting, 1 address out, 2 data coming.
  int          mp = 0;
  bit          m_own_d = 1'b0;
  logic [31:0] m_addr = '0;
  int          m_beats = 0;
  bit          m_prefer_d = 1'b0;
  bit          m_err = 1'b0;

  // Observed event counters and AR handshake log.
  int          cnt_i_beats = 0, cnt_d_beats = 0, cnt_i_last = 0, cnt_d_last = 0;
  int          cnt_i_gnt = 0, cnt_d_gnt = 0, cnt_arv = 0, cnt_rr = 0;
  logic [31:0] hs_addr[$];
  bit          hs_own_d[$];

  // Per-cycle compare of every output against the model, then advance the model.
  always @(negedge clk) begin
    bit in_data_i, in_data_d;
    if (!rst_n) begin
      mp = 0; m_err = 1'b0; m_prefer_d = 1'b0; m_beats = 0;
    end
    in_data_i = (mp == 2) && !m_own_d;
    in_data_d = (mp == 2) && m_own_d;
    chk("arvalid", m_arvalid_o, mp == 1);
    chk("rready", m_rready_o, mp == 2);
    chk("i_gnt", i_gnt_o, (mp == 1) && m_arready && !m_own_d);
    chk("d_gnt", d_gnt_o, (mp == 1) && m_arready && m_own_d);
    chk("i_rvalid", i_rvalid_o, in_data_i && m_rvalid);
    chk("d_rvalid", d_rvalid_o, in_data_d && m_rvalid);
    chk("i_rlast", i_rlast_o, in_data_i && m_rlast);
    chk("d_rlast", d_rlast_o, in_data_d && m_rlast);
    chk("i_rdata", i_rdata_o, in_data_i ? m_rdata : 32'd0);
    chk("d_rdata", d_rdata_o, in_data_d ? m_rdata : 32'd0);
    chk("err", err_o, m_err);
    if (mp == 1) chk("araddr", m_araddr_o, m_addr);
    if (rst_n) begin
      if (i_rvalid_o) cnt_i_beats++;
      if (d_rvalid_o) cnt_d_beats++;
      if (i_rvalid_o && i_rlast_o) cnt_i_last++;
      if (d_rvalid_o && d_rlast_o) cnt_d_last++;
      if (i_gnt_o) cnt_i_gnt++;
      if (d_gnt_o) cnt_d_gnt++;
      if (m_arvalid_o) cnt_arv++;
      if (m_rready_o) cnt_rr++;
      if (m_arvalid_o && m_arready) begin
        hs_addr.push_back(m_araddr_o);
        hs_own_d.push_back(d_gnt_o);
      end
      case (mp)
        0: if (i_req || d_req) begin
          m_own_d    = (i_req && d_req) ? m_prefer_d : d_req;
          m_prefer_d = !m_own_d;
          m_addr     = (m_own_d ? d_addr : i_addr) & ~32'(LW * 4 - 1);
          mp         = 1;
        end
        1: if (m_arready) begin
          mp = 2; m_beats = 0;
        end
        default: if (m_rvalid) begin
          m_beats++;
          if (m_rresp != 2'b00) m_err = 1'b1;
          if (m_rlast != ((m_beats % LW) == 0)) m_err = 1'b1;
          if (m_rlast) mp = 0;
        end
      endcase
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    i_req = 0; d_req = 0; m_arready = 0; m_rvalid = 0; m_rlast = 0; m_rresp = 0;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
  endtask

  // Wait (bounded) for arvalid, stall `delay` cycles, then complete the handshake.
  task automatic ar_hs(input int delay);
    bit ok = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (m_arvalid_o) begin ok = 1'b1; break; end
      tick();
    end
    if (!ok) chk("arvalid_timeout", 0, 1);
    repeat (delay) tick();
    m_arready = 1'b1;
    tick();
    m_arready = 1'b0;
  endtask

  // Drive R channel: vpat bit c gives rvalid in cycle c; beats numbered from 0.
  task automatic rdata_burst(input logic [15:0] vpat, input int ncyc, input int last_beat, input int err_beat);
    int b = 0;
    for (int c = 0; c < ncyc; c++) begin
      m_rvalid = vpat[c];
      if (vpat[c]) begin
        m_rdata = 32'hA500_0000 + 32'(b);
        m_rlast = (b == last_beat);
        m_rresp = (b == err_beat) ? 2'b10 : 2'b00;
        b++;
      end else begin
        m_rdata = 32'hDEAD_0000 + 32'(c);
        m_rlast = 1'b0;
        m_rresp = 2'b00;
      end
      tick();
    end
    m_rvalid = 1'b0; m_rlast = 1'b0; m_rresp = 2'b00;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int b_ib, b_il, b_ig, b_db, b_dg, b_dl, b_arv, b_rr, hb;
    logic [31:0] exp_a[4];
    bit          exp_o[4];

    // Reset state
    #1;
    chk("rst_arvalid", m_arvalid_o, 0);
    chk("rst_araddr", m_araddr_o, 0);
    chk("rst_err", err_o, 0);
    do_reset();

    // I-only fill, misaligned address, immediate arready
    b_ib = cnt_i_beats; b_il = cnt_i_last; b_ig = cnt_i_gnt; b_db = cnt_d_beats; b_dg = cnt_d_gnt;
    i_req = 1; i_addr = 32'h0000_0014;
    tick();
    chk("t1_arvalid", m_arvalid_o, 1);
    chk("t1_araddr", m_araddr_o, 32'h0000_0010);
    chk("t1_model_addr", m_addr, 32'h0000_0010);
    chk("t1_arlen", m_arlen_o, 3);
    chk("t1_arsize", m_arsize_o, 3'b010);
    chk("t1_arburst", m_arburst_o, 2'b01);
    ar_hs(0);
    i_req = 0;
    rdata_burst(16'h000F, 4, 3, -1);
    tick();
    chk("t1_i_beats", cnt_i_beats - b_ib, 4);
    chk("t1_i_last", cnt_i_last - b_il, 1);
    chk("t1_i_gnt", cnt_i_gnt - b_ig, 1);
    chk("t1_d_beats", cnt_d_beats - b_db, 0);
    chk("t1_d_gnt", cnt_d_gnt - b_dg, 0);
    chk("t1_err", err_o, 0);

    // Simultaneous requests after reset, then a second tie
    do_reset();
    hb = hs_addr.size();
    i_req = 1; d_req = 1; i_addr = 32'h0000_0100; d_addr = 32'h0010_0048;
    tick();
    ar_hs(0); i_req = 0;
    rdata_burst(16'h000F, 4, 3, -1);
    ar_hs(0); d_req = 0;
    rdata_burst(16'h000F, 4, 3, -1);
    i_req = 1; d_req = 1; i_addr = 32'h0000_0204; d_addr = 32'h0000_0308;
    tick();
    ar_hs(0); i_req = 0;
    rdata_burst(16'h000F, 4, 3, -1);
    ar_hs(0); d_req = 0;
    rdata_burst(16'h000F, 4, 3, -1);
    tick();
    exp_a[0] = 32'h0000_0100; exp_o[0] = 1'b0;
    exp_a[1] = 32'h0010_0040; exp_o[1] = 1'b1;
    exp_a[2] = 32'h0000_0200; exp_o[2] = 1'b0;
    exp_a[3] = 32'h0000_0300; exp_o[3] = 1'b1;
    chk("t2_hs_count", hs_addr.size() - hb, 4);
    for (int k = 0; k < 4; k++) begin
      if (hb + k < hs_addr.size()) begin
        chk($sformatf("t2_hs%0d_addr", k), hs_addr[hb + k], exp_a[k]);
        chk($sformatf("t2_hs%0d_owner_d", k), hs_own_d[hb + k], exp_o[k]);
      end
    end

    // arready held low for 5 cycles
    do_reset();
    b_arv = cnt_arv; b_dg = cnt_d_gnt;
    d_req = 1; d_addr = 32'h0000_2000;
    tick();
    ar_hs(5); d_req = 0;
    chk("t3_arvalid_cycles", cnt_arv - b_arv, 6);
    chk("t3_d_gnt", cnt_d_gnt - b_dg, 1);
    rdata_burst(16'h000F, 4, 3, -1);
    tick();

    // rvalid gaps 1,0,0,1,1,0,1
    b_db = cnt_d_beats; b_dl = cnt_d_last; b_rr = cnt_rr;
    d_req = 1; d_addr = 32'h0000_3000;
    tick();
    ar_hs(0); d_req = 0;
    rdata_burst(16'h0059, 7, 3, -1);
    chk("t4_idle_arvalid", m_arvalid_o, 0);
    chk("t4_idle_rready", m_rready_o, 0);
    chk("t4_d_beats", cnt_d_beats - b_db, 4);
    chk("t4_d_last", cnt_d_last - b_dl, 1);
    chk("t4_rready_cycles", cnt_rr - b_rr, 7);
    chk("t4_err", err_o, 0);

    // SLVERR on beat 2
    do_reset();
    i_req = 1; i_addr = 32'h0000_0040;
    tick();
    ar_hs(0); i_req = 0;
    rdata_burst(16'h000F, 4, 3, 1);
    chk("t5a_err", err_o, 1);
    repeat (3) tick();
    chk("t5a_err_sticky", err_o, 1);
    do_reset();
    chk("t5a_err_cleared", err_o, 0);

    // Early rlast on beat 3
    d_req = 1; d_addr = 32'h0000_4000;
    tick();
    ar_hs(0); d_req = 0;
    rdata_burst(16'h0007, 3, 2, -1);
    chk("t5b_err", err_o, 1);
    chk("t5b_back_idle", m_rready_o, 0);

    // Reset during beat 2, then a fresh D fill
    do_reset();
    d_req = 1; d_addr = 32'h0000_5000;
    tick();
    ar_hs(0); d_req = 0;
    m_rvalid = 1; m_rdata = 32'h1111_0000; m_rlast = 0;
    tick();
    m_rdata = 32'h2222_0000;
    #1;
    chk("t6_pre_rst_rvalid", d_rvalid_o, 1);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_rvalid", d_rvalid_o, 0);
    chk("t6_rst_rdata", d_rdata_o, 0);
    chk("t6_rst_rready", m_rready_o, 0);
    chk("t6_rst_araddr", m_araddr_o, 0);
    tick();
    rst_n = 1'b1;
    m_rlast = 1;
    repeat (2) tick();
    m_rvalid = 0; m_rlast = 0;
    chk("t6_stray_err", err_o, 0);
    b_db = cnt_d_beats; b_dl = cnt_d_last; hb = hs_addr.size();
    d_req = 1; d_addr = 32'h0000_6000;
    tick();
    ar_hs(0); d_req = 0;
    rdata_burst(16'h000F, 4, 3, -1);
    tick();
    chk("t6_d_beats", cnt_d_beats - b_db, 4);
    chk("t6_d_last", cnt_d_last - b_dl, 1);
    chk("t6_hs_count", hs_addr.size() - hb, 1);
    if (hb < hs_addr.size()) chk("t6_hs_addr", hs_addr[hb], 32'h0000_6000);
    chk("t6_err", err_o, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
